// File: rtl/rc5_pkg.sv
// Shared constants and FSM state encoding for the RC5 key schedule controller.
package rc5_pkg;

  localparam int unsigned W_DEF = 32;
  localparam int unsigned C_DEF = 4;
  localparam int unsigned T_DEF = 26;

  localparam logic [31:0] P = 32'hB7E15163;
  localparam logic [31:0] Q = 32'h9E3779B9;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_L    = 3'd1,
    INIT_S    = 3'd2,
    MIX_START = 3'd3,
    MIX_WAIT  = 3'd4,
    READY     = 3'd5
  } state_t;

endpackage

// File: rtl/rc5_mem_port_mux.sv
// Steers the L and S memory ports between key load, S init, mixer and encryption read.
module rc5_mem_port_mux
  import rc5_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned LW = 2,
  parameter int unsigned SW = 5
) (
  input  state_t          state,
  input  logic            keyValid,
  input  logic [W-1:0]    keyWord,
  input  logic [LW-1:0]   cnt,
  input  logic [SW-1:0]   idx,
  input  logic [W-1:0]    acc,
  input  logic [LW-1:0]   mixLAddress,
  input  logic [W-1:0]    mixLData,
  input  logic            mixLWe,
  input  logic [SW-1:0]   mixSAddress,
  input  logic [W-1:0]    mixSData,
  input  logic            mixSWe,
  input  logic [SW-1:0]   encSAddress,
  output logic [LW-1:0]   lAddress,
  output logic [W-1:0]    lData,
  output logic            lWe,
  output logic [SW-1:0]   sAddress,
  output logic [W-1:0]    sData,
  output logic            sWe
);

  always_comb begin
    lAddress = '0;
    lData    = '0;
    lWe      = 1'b0;
    sAddress = '0;
    sData    = '0;
    sWe      = 1'b0;
    case (state)
      LOAD_L: begin
        if (keyValid) begin
          lAddress = cnt;
          lData    = keyWord;
          lWe      = 1'b1;
        end
      end
      INIT_S: begin
        sAddress = idx;
        sData    = acc;
        sWe      = 1'b1;
      end
      // Mixer owns both memories, including its final write on the done cycle.
      MIX_WAIT: begin
        lAddress = mixLAddress;
        lData    = mixLData;
        lWe      = mixLWe;
        sAddress = mixSAddress;
        sData    = mixSData;
        sWe      = mixSWe;
      end
      READY: begin
        sAddress = encSAddress;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc5_key_sched_ctrl.sv
// RC5 key schedule controller: loads L, initialises S with P/Q, then hands off to the mixer.
module rc5_key_sched_ctrl
  import rc5_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned C = C_DEF,
  parameter int unsigned T = T_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iStart,
  input  logic                 iKey_valid,
  input  logic [W-1:0]         iKey_word,
  output logic                 oKey_ready,
  output logic                 oMix_rst,
  output logic                 oMix_start,
  input  logic                 iMix_done,
  input  logic [$clog2(C)-1:0] iMix_L_address,
  input  logic [W-1:0]         iMix_L_data,
  input  logic                 iMix_L_we,
  input  logic [$clog2(T)-1:0] iMix_S_address,
  input  logic [W-1:0]         iMix_S_data,
  input  logic                 iMix_S_we,
  output logic [$clog2(C)-1:0] oL_address,
  output logic [W-1:0]         oL_data,
  output logic                 oL_we,
  output logic [$clog2(T)-1:0] oS_address,
  output logic [W-1:0]         oS_data,
  output logic                 oS_we,
  input  logic [$clog2(T)-1:0] iEnc_S_address,
  output logic                 oReady,
  output logic                 oBusy
);

  localparam int unsigned LW = $clog2(C);
  localparam int unsigned SW = $clog2(T);

  state_t        state, stateNext;
  logic [LW-1:0] cnt, cntNext;
  logic [SW-1:0] idx, idxNext;
  logic [W-1:0]  acc, accNext;
  logic          lastKey, lastS;

  assign lastKey = (cnt == LW'(C - 1));
  assign lastS   = (idx == SW'(T - 1));

  // State, counters and status flags; flags are decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      acc        <= W'(P);
      oReady     <= 1'b0;
      oBusy      <= 1'b0;
      oMix_rst   <= 1'b1;
      oMix_start <= 1'b0;
      oKey_ready <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      idx        <= idxNext;
      acc        <= accNext;
      oReady     <= (stateNext == READY);
      oBusy      <= (stateNext inside {LOAD_L, INIT_S, MIX_START, MIX_WAIT});
      oMix_rst   <= !(stateNext inside {MIX_START, MIX_WAIT});
      oMix_start <= (stateNext == MIX_START);
      oKey_ready <= (stateNext == LOAD_L);
    end
  end

  // Next state; counters idle at zero and the accumulator rests at P outside their phases.
  always_comb begin
    stateNext = state;
    cntNext   = '0;
    idxNext   = '0;
    accNext   = W'(P);
    case (state)
      IDLE: begin
        if (iStart) stateNext = LOAD_L;
      end
      LOAD_L: begin
        cntNext = cnt;
        if (iKey_valid) begin
          cntNext = lastKey ? '0 : cnt + LW'(1);
          if (lastKey) stateNext = INIT_S;
        end
      end
      INIT_S: begin
        idxNext = lastS ? '0 : idx + SW'(1);
        accNext = acc + W'(Q);
        if (lastS) stateNext = MIX_START;
      end
      MIX_START: stateNext = MIX_WAIT;
      MIX_WAIT: begin
        if (iMix_done) stateNext = READY;
      end
      READY: begin
        if (iStart) stateNext = LOAD_L;
      end
      default: stateNext = IDLE;
    endcase
  end

  rc5_mem_port_mux #(
    .W (W),
    .LW(LW),
    .SW(SW)
  ) uPortMux (
    .state      (state),
    .keyValid   (iKey_valid),
    .keyWord    (iKey_word),
    .cnt        (cnt),
    .idx        (idx),
    .acc        (acc),
    .mixLAddress(iMix_L_address),
    .mixLData   (iMix_L_data),
    .mixLWe     (iMix_L_we),
    .mixSAddress(iMix_S_address),
    .mixSData   (iMix_S_data),
    .mixSWe     (iMix_S_we),
    .encSAddress(iEnc_S_address),
    .lAddress   (oL_address),
    .lData      (oL_data),
    .lWe        (oL_we),
    .sAddress   (oS_address),
    .sData      (oS_data),
    .sWe        (oS_we)
  );

endmodule

// File: doc/rc5_key_sched_ctrl.md
RC5_KEY_SCHED_CTRL -- requirements
Module: rc5_key_sched_ctrl

Interface
REQ-001 Parameter W, default 32: word width in bits.
REQ-002 Parameter C, default 4: number of L (key) words.
REQ-003 Parameter T, default 26: number of S table words.
REQ-004 clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1: reset, synchronous, active-low.
REQ-006 iStart  in  1: request a full key schedule.
REQ-007 iKey_valid / iKey_word  in  1 / W: key word stream, L[0] first.
REQ-008 oKey_ready  out  1: key word accepted this cycle when high together with iKey_valid.
REQ-009 oMix_rst / oMix_start  out  1 / 1: active-high reset and start for the key mixer.
REQ-010 iMix_done  in  1: sticky done from the mixer.
REQ-011 iMix_L_address / iMix_L_data / iMix_L_we  in  clog2(C) / W / 1: mixer L port.
REQ-012 iMix_S_address / iMix_S_data / iMix_S_we  in  clog2(T) / W / 1: mixer S port.
REQ-013 oL_address / oL_data / oL_we  out  clog2(C) / W / 1: L memory port.
REQ-014 oS_address / oS_data / oS_we  out  clog2(T) / W / 1: S memory port.
REQ-015 iEnc_S_address  in  clog2(T): encryption core S read address.
REQ-016 oReady / oBusy  out  1 / 1: S table valid / schedule in progress.

Function
REQ-017 FSM states: IDLE, LOAD_L, INIT_S, MIX_START, MIX_WAIT, READY; encoding in shared package.
REQ-018 IDLE: on iStart=1 -> LOAD_L and clear the word counter; otherwise stay.
REQ-019 LOAD_L: oKey_ready=1; on iKey_valid: oL_address=cnt, oL_data=iKey_word, oL_we=1 (combinational); cnt increments; the edge accepting word C-1 -> INIT_S.
REQ-020 LOAD_L with iKey_valid=0: no write, no count change, no timeout.
REQ-021 INIT_S: one write per cycle, oS_we=1, oS_address=i, oS_data=acc; acc starts at P=0xB7E15163 and adds Q=0x9E3779B9 mod 2^W each cycle; i from 0 to T-1; after the write of i=T-1 -> MIX_START.
REQ-022 MIX_START: exactly one cycle with oMix_start=1, oMix_rst=0; -> MIX_WAIT.
REQ-023 MIX_WAIT: L and S ports SHALL be driven by the iMix_* inputs unchanged, including we.
REQ-024 MIX_WAIT: on iMix_done=1, the mixer ports SHALL remain routed for that cycle so its final write completes; next state READY.
REQ-025 oMix_rst=1 in every state except MIX_START and MIX_WAIT; oMix_start=0 except in MIX_START.
REQ-026 READY: oReady=1, oS_we=0, oL_we=0, oS_address=iEnc_S_address.
REQ-027 READY with iStart=1 -> LOAD_L; oReady SHALL drop on the following cycle.
REQ-028 iStart in LOAD_L through MIX_WAIT SHALL be ignored.
REQ-029 oBusy=1 in LOAD_L, INIT_S, MIX_START, MIX_WAIT; else 0.
REQ-030 Outside the states listed above, all we outputs SHALL be 0, addresses and data 0, and oKey_ready=0.
REQ-031 Counter i wraps at T, cnt at C, never exceeding range; address widths SHALL be clog2 of the depth.

Reset
REQ-032 rst=0 at a clock edge SHALL force IDLE, cnt=0, i=0, acc=P, oReady=0, oBusy=0, oMix_rst=1, oMix_start=0, all we=0; this holds in every state, including mid-MIX_WAIT, without waiting for iMix_done.
REQ-033 Reset SHALL take priority over iStart and iKey_valid in the same cycle.

Structure
REQ-034 Shared package rc5_pkg SHALL hold P, Q, the W/C/T defaults and the FSM state encoding.
REQ-035 The memory port multiplexer SHALL be one sub-module, rc5_mem_port_mux, selected by FSM state.
REQ-036 Outputs other than registered FSM flags SHALL be combinational from registered state and the iMix_*/iEnc_* inputs; there is no added port latency.

Verification
REQ-037 Reset then iStart, 4 keys 0x11111111..0x44444444 with valid every cycle -> L[0..3] written on 4 consecutive cycles; INIT_S starts on the next cycle.
REQ-038 INIT_S -> S[0]=0xB7E15163, S[1]=0x5618CB1C, S[2]=0xF45044D5; exactly 26 write cycles.
REQ-039 Key words with valid toggling 1,0,1,0 -> exactly 4 writes at addresses 0..3; no write in valid=0 cycles.
REQ-040 Mixer model asserts done with S_we=1, address 25 -> that write reaches oS_*; READY on the next cycle; oMix_rst=1 thereafter.
REQ-041 rst=0 during MIX_WAIT -> IDLE on the next cycle, oMix_rst=1, all we=0, oReady=0.
REQ-042 READY with iEnc_S_address=7 -> oS_address=7, oS_we=0; iStart in READY -> LOAD_L and oReady=0 on the next cycle.
